// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: word type, MEM FSM state enum,
// and data-memory byte-enable encodings.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        IND_PTR,
        IND_ACCESS,
        HOLD
    } lc3b_mem_state;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for data memory: write enables, replicated store
// data and sign-extended load data. Ports: addr0, byte_op, wdata, rdata
// in; byte_enable, wdata_lane, rdata_lane out.
module mem_byte_lane
    import lc3b_types::*;
(
    input  logic       addr0,
    input  logic       byte_op,
    input  lc3b_word   wdata,
    input  lc3b_word   rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   wdata_lane,
    output lc3b_word   rdata_lane
);

    logic [7:0] rbyte;

    always_comb begin
        byte_enable = BE_WORD;
        wdata_lane  = wdata;
        rdata_lane  = rdata;
        rbyte       = addr0 ? rdata[15:8] : rdata[7:0];
        if (byte_op) begin
            byte_enable = addr0 ? BE_HI : BE_LO;
            wdata_lane  = {wdata[7:0], wdata[7:0]};
            rdata_lane  = {{8{rbyte[7]}}, rbyte};
        end
    end

endmodule

// File: rtl/mem_access.sv
// LC-3b MEM stage: LDR/STR/LDB/STB/LDI/STI data-memory handshake FSM.
// Ports: execute controls in, dmem_* request/response, mem_stall,
// rdata_out/done to writeback. Option MEM_ALIGN_CHECK_EN adds align_err.
module mem_access
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              indirect_in,
    input  logic              byte_in,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              pipe_advance,
    output logic [ADDR_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [1:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    lc3b_mem_state state, state_d;

    lc3b_word      addr_d, wd_d, rdata_d, wdata_q, wdata_q_d;
    logic          rd_d, wr_d, done_d;
    logic [1:0]    be_d;
    logic [15:1]   ptr, ptr_d;
    logic          is_wr, is_wr_d;
    logic          byte_q, byte_d;
    logic          a0_q, a0_d;
    logic          op_wr;
`ifdef MEM_ALIGN_CHECK_EN
    logic          err_d;
`endif

    logic          lane_a0, lane_byte;
    logic [1:0]    lane_be;
    lc3b_word      lane_wdata, lane_rdata;

    // Loads win if execute ever flags both, so read/write stay exclusive.
    assign op_wr = mem_write_in & ~mem_read_in;

    // Launch uses live inputs; the load result uses the latched lane.
    assign lane_a0   = (state == IDLE) ? address_in[0] : a0_q;
    assign lane_byte = (state == IDLE) ? (byte_in & ~indirect_in) : byte_q;

    mem_byte_lane u_lane (
        .addr0       (lane_a0),
        .byte_op     (lane_byte),
        .wdata       (wdata_in),
        .rdata       (dmem_rdata),
        .byte_enable (lane_be),
        .wdata_lane  (lane_wdata),
        .rdata_lane  (lane_rdata)
    );

    always_comb begin
        state_d   = state;
        addr_d    = dmem_address;
        rd_d      = dmem_read;
        wr_d      = dmem_write;
        be_d      = dmem_byte_enable;
        wd_d      = dmem_wdata;
        rdata_d   = rdata_out;
        done_d    = done;
        ptr_d     = ptr;
        is_wr_d   = is_wr;
        byte_d    = byte_q;
        a0_d      = a0_q;
        wdata_q_d = wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        err_d     = align_err;
`endif
        mem_stall = 1'b0;

        unique case (state)
            IDLE: begin
                done_d = 1'b0;
                if (valid_in && (mem_read_in || mem_write_in)) begin
                    mem_stall = 1'b1;
                    is_wr_d   = op_wr;
                    byte_d    = byte_in & ~indirect_in;
                    a0_d      = address_in[0];
                    wdata_q_d = wdata_in;
                    addr_d    = {address_in[15:1], 1'b0};
                    if (indirect_in) begin
                        state_d = IND_PTR;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        be_d    = BE_NONE;
                        wd_d    = '0;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (!byte_in && address_in[0]) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ACCESS;
                        rd_d    = ~op_wr;
                        wr_d    = op_wr;
                        be_d    = op_wr ? lane_be : BE_NONE;
                        wd_d    = op_wr ? lane_wdata : '0;
                    end
                end
            end

            ACCESS, IND_ACCESS: begin
                mem_stall = 1'b1;
                // Pointer register already drove this address; keep it.
                if (state == IND_ACCESS) addr_d = {ptr, 1'b0};
                if (dmem_resp) begin
                    state_d = HOLD;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    be_d    = BE_NONE;
                    wd_d    = '0;
                    done_d  = 1'b1;
                    if (!is_wr) rdata_d = lane_rdata;
                end
            end

            IND_PTR: begin
                mem_stall = 1'b1;
                if (dmem_resp) begin
                    ptr_d  = dmem_rdata[15:1];
                    addr_d = {dmem_rdata[15:1], 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
                    if (dmem_rdata[0]) begin
                        state_d = HOLD;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        done_d  = 1'b1;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = IND_ACCESS;
                        rd_d    = ~is_wr;
                        wr_d    = is_wr;
                        be_d    = is_wr ? BE_WORD : BE_NONE;
                        wd_d    = is_wr ? wdata_q : '0;
                    end
                end
            end

            HOLD: begin
                if (pipe_advance) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            dmem_address     <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= BE_NONE;
            dmem_wdata       <= '0;
            rdata_out        <= '0;
            done             <= 1'b0;
            ptr              <= '0;
            is_wr            <= 1'b0;
            byte_q           <= 1'b0;
            a0_q             <= 1'b0;
            wdata_q          <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err        <= 1'b0;
`endif
        end else begin
            state            <= state_d;
            dmem_address     <= addr_d;
            dmem_read        <= rd_d;
            dmem_write       <= wr_d;
            dmem_byte_enable <= be_d;
            dmem_wdata       <= wd_d;
            rdata_out        <= rdata_d;
            done             <= done_d;
            ptr              <= ptr_d;
            is_wr            <= is_wr_d;
            byte_q           <= byte_d;
            a0_q             <= a0_d;
            wdata_q          <= wdata_q_d;
`ifdef MEM_ALIGN_CHECK_EN
            align_err        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model
// with a behavioural data memory answering at random latencies.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, mem_read_in, mem_write_in;
    logic        indirect_in, byte_in, pipe_advance;
    logic [15:0] address_in, wdata_in;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata, rdata_out;
    logic        dmem_read, dmem_write, dmem_resp, mem_stall, done;
    logic [1:0]  dmem_byte_enable;

    int vectors = 0;
    int errors  = 0;

    localparam int LDR = 0, STR = 1, LDB = 2, STB = 3, LDI = 4, STI = 5;

    logic [15:0] mem [logic [15:0]];

    logic [15:0] e_addr [2];
    logic        e_wr   [2];
    logic [1:0]  e_be   [2];
    logic [15:0] e_wd   [2];
    int          lats   [2];

    mem_access dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .indirect_in      (indirect_in),
        .byte_in          (byte_in),
        .address_in       (address_in),
        .wdata_in         (wdata_in),
        .pipe_advance     (pipe_advance),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_stall        (mem_stall),
        .rdata_out        (rdata_out),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return (b >= 8'd128) ? (16'hFF00 | 16'(b)) : 16'(b);
    endfunction

    task automatic run_op(input int op, input logic [15:0] a,
                          input logic [15:0] wd, input int lat0,
                          input int lat1, input int hold);
        logic        is_rd, is_byte, is_ind, got_done;
        logic [15:0] wa, w, p, exp_res, m;
        int          n_acc, idx, cnt, reqc, stallc, cyc, exp_cyc;
        is_rd   = (op == LDR) || (op == LDB) || (op == LDI);
        is_byte = (op == LDB) || (op == STB);
        is_ind  = (op == LDI) || (op == STI);
        wa      = a & 16'hFFFE;
        exp_res = 16'h0;
        lats[0] = lat0;
        lats[1] = lat1;
        if (!is_ind) begin
            n_acc     = 1;
            e_addr[0] = wa;
            e_wr[0]   = !is_rd;
            if (is_rd) e_be[0] = 2'b00;
            else if (!is_byte) e_be[0] = 2'b11;
            else e_be[0] = a[0] ? 2'b10 : 2'b01;
            e_wd[0] = is_byte ? {wd[7:0], wd[7:0]} : wd;
            if (is_rd) begin
                w = rd_mem(wa);
                exp_res = is_byte ? sext8(a[0] ? w[15:8] : w[7:0]) : w;
            end
        end else begin
            n_acc     = 2;
            p         = rd_mem(wa);
            e_addr[0] = wa;
            e_wr[0]   = 1'b0;
            e_be[0]   = 2'b00;
            e_wd[0]   = 16'h0;
            e_addr[1] = p & 16'hFFFE;
            e_wr[1]   = !is_rd;
            e_be[1]   = is_rd ? 2'b00 : 2'b11;
            e_wd[1]   = wd;
            if (is_rd) exp_res = rd_mem(e_addr[1]);
        end
        exp_cyc = 0;
        for (int i = 0; i < n_acc; i++) exp_cyc += lats[i] + 1;

        @(negedge clk);
        valid_in     = 1'b1;
        mem_read_in  = is_rd;
        mem_write_in = !is_rd;
        indirect_in  = is_ind;
        byte_in      = is_byte;
        address_in   = a;
        wdata_in     = wd;
        #1;
        check("stall_launch", mem_stall, 1);
        check("no_req_launch", dmem_read | dmem_write, 0);

        idx = 0; cnt = 0; reqc = 0; stallc = 0; cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            dmem_resp = 1'b0;
            check("rw_excl", dmem_read & dmem_write, 0);
            if (done) got_done = 1'b1;
            else begin
                if (mem_stall) stallc++;
                if (dmem_read | dmem_write) begin
                    if (idx >= n_acc) check("extra_access", idx, n_acc - 1);
                    else if (cnt == 0) begin
                        check("acc_addr", dmem_address, e_addr[idx]);
                        check("acc_write", dmem_write, e_wr[idx]);
                        check("acc_be", dmem_byte_enable, e_be[idx]);
                        if (e_wr[idx])
                            check("acc_wdata", dmem_wdata, e_wd[idx]);
                    end else begin
                        check("acc_held", dmem_address, e_addr[idx]);
                    end
                    cnt++;
                    reqc++;
                    if (idx < n_acc && cnt == lats[idx] + 1) begin
                        dmem_resp = 1'b1;
                        m = rd_mem(dmem_address);
                        if (dmem_write) begin
                            if (dmem_byte_enable[0]) m[7:0] = dmem_wdata[7:0];
                            if (dmem_byte_enable[1]) m[15:8] = dmem_wdata[15:8];
                            mem[dmem_address] = m;
                        end
                        dmem_rdata = m;
                        cnt = 0;
                        idx++;
                    end
                end
            end
        end
        dmem_resp = 1'b0;
        check("done_seen", got_done, 1);
        check("accesses", idx, n_acc);
        check("req_cycles", reqc, exp_cyc);
        check("stall_cycles", stallc, exp_cyc);
        check("hold_stall", mem_stall, 0);
        check("hold_no_req", dmem_read | dmem_write, 0);
        if (is_rd) check("rdata", rdata_out, exp_res);

        valid_in = 1'b0;
        if (hold > 0) begin
            pipe_advance = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_done", done, 1);
                check("hold_quiet", dmem_read | dmem_write, 0);
                if (is_rd) check("hold_rdata", rdata_out, exp_res);
            end
            pipe_advance = 1'b1;
        end
        @(negedge clk);
        check("done_fall", done, 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        indirect_in  = 1'b0;
        byte_in      = 1'b0;
        address_in   = 16'h0;
        wdata_in     = 16'h0;
        pipe_advance = 1'b1;
        dmem_rdata   = 16'h0;
        dmem_resp    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read", dmem_read, 0);
        check("rst_write", dmem_write, 0);
        check("rst_be", dmem_byte_enable, 0);
        check("rst_addr", dmem_address, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_done", done, 0);
        check("rst_stall", mem_stall, 0);
        reset_n = 1'b1;

        // valid_in low, stray response: nothing happens
        @(negedge clk);
        mem_read_in = 1'b1;
        dmem_resp   = 1'b1;
        #1;
        check("idle_nostall", mem_stall, 0);
        @(negedge clk);
        dmem_resp = 1'b0;
        check("idle_noreq", dmem_read | dmem_write, 0);
        check("idle_nodone", done, 0);
        valid_in    = 1'b1;
        mem_read_in = 1'b0;
        #1;
        check("nonmem_nostall", mem_stall, 0);
        @(negedge clk);
        check("nonmem_noreq", dmem_read | dmem_write, 0);
        valid_in = 1'b0;

        mem[16'h3000] = 16'hBEEF;
        run_op(LDR, 16'h3001, 16'h0, 1, 0, 0);
        mem[16'h4000] = 16'h80FF;
        run_op(LDB, 16'h4001, 16'h0, 0, 0, 0);
        run_op(LDB, 16'h4000, 16'h0, 0, 0, 0);
        run_op(STB, 16'h5001, 16'h1234, 0, 0, 0);
        mem[16'h6000] = 16'h7000;
        mem[16'h7000] = 16'h00AA;
        run_op(LDI, 16'h6000, 16'h0, 0, 0, 0);
        mem[16'h6000] = 16'h7002;
        run_op(STI, 16'h6000, 16'hCAFE, 1, 0, 0);
        check("sti_mem", mem[16'h7002], 16'hCAFE);
        run_op(LDR, 16'h3000, 16'h0, 0, 0, 3);

        for (int t = 0; t < 60; t++) begin
            run_op($urandom_range(0, 5), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // reset in the middle of an access
        @(negedge clk);
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        mem_write_in = 1'b0;
        indirect_in  = 1'b0;
        byte_in      = 1'b0;
        address_in   = 16'h3000;
        @(negedge clk);
        check("mid_read", dmem_read, 1);
        reset_n  = 1'b0;
        valid_in = 1'b0;
        #1;
        check("rst_drop_read", dmem_read, 0);
        check("rst_drop_stall", mem_stall, 0);
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h5555;
        @(negedge clk);
        dmem_resp = 1'b0;
        reset_n   = 1'b1;
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_resp_done", done, 0);
            check("late_resp_req", dmem_read | dmem_write, 0);
            check("late_resp_rdata", rdata_out, 0);
            @(negedge clk);
        end
        run_op(LDR, 16'h3001, 16'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
